multi_cycle_ctrl: RTL

Multi-cycle control FSM that sequences the single-cycle datapath's register file, ALU, data memory and next-PC logic over several clock cycles per instruction. It sits beside the datapath, takes opcode/funct from the instruction register and `zero` from the ALU, and drives every datapath select and write enable plus the PC/IR write strobes. Supported set: addu, subu, ori, lui, sll, lw, sw, beq, jal, jr; anything else is flagged illegal and skipped.

---
 rtl/multi_cycle_ctrl_pkg.sv | 60 ++++++
 rtl/multi_cycle_ctrl_if.sv | 43 ++++
 rtl/multi_cycle_ctrl_instr_decoder.sv | 45 ++++
 rtl/multi_cycle_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// ============================================================================
// Module : mcc_pkg
// Shared encodings for the multi-cycle controller: states, instruction
// classes, opcode/funct values and datapath select codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mcc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_JUMP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE_ALU = 4'd0,
    C_SLL       = 4'd1,
    C_ORI       = 4'd2,
    C_LUI       = 4'd3,
    C_LW        = 4'd4,
    C_SW        = 4'd5,
    C_BEQ       = 4'd6,
    C_JAL       = 4'd7,
    C_JR        = 4'd8,
    C_ILL       = 4'd9
  } iclass_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_jal   = 6'b000011;

  localparam logic [5:0] c_fn_addu  = 6'b100001;
  localparam logic [5:0] c_fn_subu  = 6'b100011;
  localparam logic [5:0] c_fn_sll   = 6'b000000;
  localparam logic [5:0] c_fn_jr    = 6'b001000;

  localparam logic [1:0] c_alu_add  = 2'b00;
  localparam logic [1:0] c_alu_sub  = 2'b01;
  localparam logic [1:0] c_alu_or   = 2'b10;

  localparam logic [1:0] c_wr_rt    = 2'b00;
  localparam logic [1:0] c_wr_rd    = 2'b01;
  localparam logic [1:0] c_wr_ra    = 2'b10;

  localparam logic [1:0] c_wd_alu   = 2'b00;
  localparam logic [1:0] c_wd_dm    = 2'b01;
  localparam logic [1:0] c_wd_pc4   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multi_cycle_ctrl_if.sv
// ============================================================================
// Module : multi_cycle_ctrl_if
// Controller <-> datapath bundle: instruction fields and flags in, selects out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic [1:0] WRsel;
  logic [1:0] WDsel;
  logic [1:0] ALUOp;
  logic       EXTOp;
  logic       Bsel;
  logic       LUIsel;
  logic       Sll;
  logic       Br;
  logic       Jal;
  logic       Jr;
  logic       instr_done;
  logic       illegal;
  logic [2:0] state;

  // master is the controller, slave is the datapath
  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, RFWr, DMWr, WRsel, WDsel, ALUOp, EXTOp, Bsel,
           LUIsel, Sll, Br, Jal, Jr, instr_done, illegal, state
  );
  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, RFWr, DMWr, WRsel, WDsel, ALUOp, EXTOp, Bsel,
           LUIsel, Sll, Br, Jal, Jr, instr_done, illegal, state
  );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_ctrl_instr_decoder.sv
// ============================================================================
// Module : instr_decoder
// Combinational op/funct classifier; sub flags subu within the R-type ALU class.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decoder
  import mcc_pkg::*;
(
  input  wire logic [5:0] op,
  input  wire logic [5:0] funct,
  output iclass_t         cls,
  output logic            sub
);

  always_comb begin
    cls = C_ILL;
    sub = 1'b0;
    case (op)
      c_op_rtype: begin
        case (funct)
          c_fn_addu: cls = C_RTYPE_ALU;
          c_fn_subu: begin
            cls = C_RTYPE_ALU;
            sub = 1'b1;
          end
          c_fn_sll:  cls = C_SLL;
          c_fn_jr:   cls = C_JR;
          default:   cls = C_ILL;
        endcase
      end
      c_op_ori: cls = C_ORI;
      c_op_lui: cls = C_LUI;
      c_op_lw:  cls = C_LW;
      c_op_sw:  cls = C_SW;
      c_op_beq: cls = C_BEQ;
      c_op_jal: cls = C_JAL;
      default:  cls = C_ILL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// Module : multi_cycle_ctrl
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_cycle_ctrl
  import mcc_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           reset,
  multi_cycle_ctrl_if.master  bus
);

  state_t     r_state;
  state_t     w_next;
  iclass_t    r_cls;
  logic       r_sub;
  iclass_t    w_dec_cls;
  logic       w_dec_sub;

  logic       w_pcwr, w_irwr, w_rfwr, w_dmwr;
  logic [1:0] w_wrsel, w_wdsel, w_aluop;
  logic       w_ext, w_bsel, w_lui, w_sll, w_br, w_jal, w_jr;
  logic       w_done, w_ill;

  instr_decoder u_dec (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (w_dec_cls),
    .sub   (w_dec_sub)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cls   <= C_ILL;
      r_sub   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
        r_sub <= w_dec_sub;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_pcwr  = 1'b0;
    w_irwr  = 1'b0;
    w_rfwr  = 1'b0;
    w_dmwr  = 1'b0;
    w_wrsel = c_wr_rt;
    w_wdsel = c_wd_alu;
    w_aluop = c_alu_add;
    w_ext   = 1'b0;
    w_bsel  = 1'b0;
    w_lui   = 1'b0;
    w_sll   = 1'b0;
    w_br    = 1'b0;
    w_jal   = 1'b0;
    w_jr    = 1'b0;
    w_done  = 1'b0;
    w_ill   = 1'b0;

    // datapath selects follow the latched class for the whole EXE/MEM/WB span
    if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
      case (r_cls)
        C_RTYPE_ALU: begin
          w_wrsel = c_wr_rd;
          w_aluop = r_sub ? c_alu_sub : c_alu_add;
        end
        C_SLL: begin
          w_wrsel = c_wr_rd;
          w_sll   = 1'b1;
        end
        C_ORI, C_LUI: begin
          w_aluop = c_alu_or;
          w_bsel  = 1'b1;
          w_lui   = (r_cls == C_LUI);
        end
        C_LW: begin
          w_wdsel = c_wd_dm;
          w_bsel  = 1'b1;
          w_ext   = 1'b1;
        end
        C_SW: begin
          w_bsel  = 1'b1;
          w_ext   = 1'b1;
        end
        C_BEQ: begin
          w_aluop = c_alu_sub;
          w_br    = 1'b1;
        end
        default: ;
      endcase
    end

    case (r_state)
      S_FETCH: begin
        w_irwr = 1'b1;
        w_pcwr = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_dec_cls)
          C_ILL: begin
            w_ill  = 1'b1;
            w_next = S_FETCH;
          end
          C_JAL, C_JR: w_next = S_JUMP;
          default:     w_next = S_EXE;
        endcase
      end
      S_EXE: begin
        case (r_cls)
          C_BEQ: begin
            w_pcwr = bus.zero;
            w_done = 1'b1;
            w_next = S_FETCH;
          end
          C_LW, C_SW:                        w_next = S_MEM;
          C_RTYPE_ALU, C_SLL, C_ORI, C_LUI:  w_next = S_WB;
          default:                           w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (r_cls == C_SW) begin
          w_dmwr = 1'b1;
          w_done = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_rfwr = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        w_pcwr = 1'b1;
        w_done = 1'b1;
        w_next = S_FETCH;
        if (r_cls == C_JAL) begin
          w_jal   = 1'b1;
          w_rfwr  = 1'b1;
          w_wrsel = c_wr_ra;
          w_wdsel = c_wd_pc4;
        end else begin
          w_jr    = 1'b1;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  // reset forces every output low immediately, even mid-instruction
  assign bus.PCWr       = w_pcwr & ~reset;
  assign bus.IRWr       = w_irwr & ~reset;
  assign bus.RFWr       = w_rfwr & ~reset;
  assign bus.DMWr       = w_dmwr & ~reset;
  assign bus.WRsel      = reset ? 2'b00 : w_wrsel;
  assign bus.WDsel      = reset ? 2'b00 : w_wdsel;
  assign bus.ALUOp      = reset ? 2'b00 : w_aluop;
  assign bus.EXTOp      = w_ext  & ~reset;
  assign bus.Bsel       = w_bsel & ~reset;
  assign bus.LUIsel     = w_lui  & ~reset;
  assign bus.Sll        = w_sll  & ~reset;
  assign bus.Br         = w_br   & ~reset;
  assign bus.Jal        = w_jal  & ~reset;
  assign bus.Jr         = w_jr   & ~reset;
  assign bus.instr_done = w_done & ~reset;
  assign bus.illegal    = w_ill  & ~reset;
  assign bus.state      = reset ? 3'd0 : r_state;

endmodule

`default_nettype wire
